// File: rtl/uart_tx_conf_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS layout, TX FSM state encodings and the bit-timer reload helper.
package uart_tx_conf_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BAUD_W = 16;
  localparam int unsigned CNT_W  = 3;

  // Register offsets, decoded from addr[3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  // TX FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // STATUS register layout, bit 0 is the last field
  typedef struct packed {
    logic [CNT_W-1:0] count;     // [6:4]
    logic             overflow;  // [3]
    logic             busy;      // [2]
    logic             empty;     // [1]
    logic             full;      // [0]
  } status_t;

  // Bit-timer reload value: a divisor of 0 behaves like 1
  function automatic logic [BAUD_W-1:0] bit_reload(input logic [BAUD_W-1:0] div);
    return (div == BAUD_W'(0)) ? BAUD_W'(0) : div - BAUD_W'(1);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO with wrap-bit pointers.
// Ports: clk, reset (async active-low), push/wdata, pop, head_c (current head),
// full_c, empty_c, count_c (entries held). A push while full is accepted only
// when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty_c = (wptr == rptr);
  assign full_c  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count_c = wptr - rptr;
  assign head_c  = mem[rptr[AW-1:0]];

  // When full, a simultaneous pop frees the slot the push lands in
  assign push_ok = push && (!full_c || pop);
  assign pop_ok  = pop && !empty_c;

  // Pointer update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop_ok)  rptr <= rptr + PW'(1);
    end
  end

  // Storage, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_conf.sv
// Memory-mapped 8N1 UART transmitter on the data-side SRAM-like bus.
// Ports: clk, reset (async active-low); uart_en/uart_wen/uart_addr/uart_wdata
// bus access (wen==0 is a read); uart_rdata registered read data (1-cycle
// latency, holds between reads); txd serial line (idle high); tx_irq high
// while the FIFO is empty and the shifter idle.
module uart_tx_conf
  import uart_tx_conf_pkg::*;
#(
  parameter int unsigned       XLEN         = 32,
  parameter int unsigned       FIFO_DEPTH   = 4,
  parameter logic [BAUD_W-1:0] BAUD_DIV_RST = 16'd868
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            uart_en,
  input  logic [3:0]      uart_wen,
  input  logic [XLEN-1:0] uart_addr,
  input  logic [XLEN-1:0] uart_wdata,
  output logic [XLEN-1:0] uart_rdata,
  output logic            txd,
  output logic            tx_irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic              wr;
  logic              rd;
  logic [1:0]        sel;
  logic              push;
  logic              drop;

  // FIFO
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [BYTE_W-1:0] fifo_head;

  // FSM and datapath
  logic [1:0]        state, state_nxt;
  logic [BAUD_W-1:0] timer, timer_nxt;
  logic [2:0]        bit_idx, idx_nxt;
  logic [BYTE_W-1:0] shift, shift_nxt;
  logic              txd_nxt;
  logic              irq_nxt;
  logic [BAUD_W-1:0] reload;
  logic              bit_end;
  logic [CW-1:0]     count_after;

  // Registers
  logic [BAUD_W-1:0] baud_div, baud_nxt;
  logic              overflow, ovf_nxt;
  logic [XLEN-1:0]   rdata_nxt;
  status_t           status;

  logic              unused_bits;
  assign unused_bits = ^{uart_addr[XLEN-1:4], uart_addr[1:0],
                         uart_wdata[XLEN-1:16], uart_wen[3:2]};

  assign wr   = uart_en && (uart_wen != 4'b0000);
  assign rd   = uart_en && (uart_wen == 4'b0000);
  assign sel  = uart_addr[3:2];
  assign push = wr && (sel == REG_TXDATA) && uart_wen[0];
  assign drop = push && fifo_full && !pop;

  assign reload  = bit_reload(baud_div);
  assign bit_end = (timer == BAUD_W'(0));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wdata   (uart_wdata[BYTE_W-1:0]),
    .head_c  (fifo_head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count_c (fifo_count)
  );

  // STATUS view of the current state
  always_comb begin
    status          = '0;
    status.full     = fifo_full;
    status.empty    = fifo_empty;
    status.busy     = (state != ST_IDLE);
    status.overflow = overflow;
    status.count    = CNT_W'(fifo_count);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state, bit timer, shifter and registered-output next values
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    pop       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_head;
          timer_nxt = reload;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt = ST_DATA;
          idx_nxt   = 3'd0;
          timer_nxt = reload;
        end else begin
          timer_nxt = timer - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_nxt = {1'b0, shift[BYTE_W-1:1]};
          timer_nxt = reload;
          if (bit_idx == 3'd7) state_nxt = ST_STOP;
          else                 idx_nxt   = bit_idx + 3'd1;
        end else begin
          timer_nxt = timer - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          // Chain straight into the next frame so bursts are gap-free
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = fifo_head;
            timer_nxt = reload;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          timer_nxt = timer - BAUD_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    case (state_nxt)
      ST_START: txd_nxt = 1'b0;
      ST_DATA:  txd_nxt = shift_nxt[0];
      default:  txd_nxt = 1'b1;
    endcase

    // Occupancy after this edge, so tx_irq tracks the registered state exactly
    count_after = fifo_count + CW'(push && (!fifo_full || pop)) - CW'(pop);
    irq_nxt     = (state_nxt == ST_IDLE) && (count_after == CW'(0));
  end

  // Register writes and read-data selection
  always_comb begin
    baud_nxt  = baud_div;
    ovf_nxt   = overflow;
    rdata_nxt = uart_rdata;

    if (drop)
      ovf_nxt = 1'b1;
    else if (wr && (sel == REG_STATUS) && uart_wen[0] && uart_wdata[3])
      ovf_nxt = 1'b0;

    if (wr && (sel == REG_BAUDDIV)) begin
      if (uart_wen[0]) baud_nxt[7:0]  = uart_wdata[7:0];
      if (uart_wen[1]) baud_nxt[15:8] = uart_wdata[15:8];
    end

    if (rd) begin
      case (sel)
        REG_TXDATA:  rdata_nxt = '0;
        REG_STATUS:  rdata_nxt = XLEN'(status);
        REG_BAUDDIV: rdata_nxt = XLEN'(baud_div);
        REG_RSVD:    rdata_nxt = '0;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer      <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      txd        <= 1'b1;
      tx_irq     <= 1'b1;
      baud_div   <= BAUD_DIV_RST;
      overflow   <= 1'b0;
      uart_rdata <= '0;
    end else begin
      timer      <= timer_nxt;
      bit_idx    <= idx_nxt;
      shift      <= shift_nxt;
      txd        <= txd_nxt;
      tx_irq     <= irq_nxt;
      baud_div   <= baud_nxt;
      overflow   <= ovf_nxt;
      uart_rdata <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_conf.sv
// Scoreboard bench for uart_tx_conf: the driver queues expected read data and
// expected serial frames; two monitors compare as the DUT produces them.
module tb_uart_tx_conf;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            uart_en;
  logic [3:0]      uart_wen;
  logic [XLEN-1:0] uart_addr;
  logic [XLEN-1:0] uart_wdata;
  logic [XLEN-1:0] uart_rdata;
  logic            txd;
  logic            tx_irq;

  always #5 clk = ~clk;

  uart_tx_conf #(
    .XLEN         (XLEN),
    .FIFO_DEPTH   (4),
    .BAUD_DIV_RST (16'd868)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_en    (uart_en),
    .uart_wen   (uart_wen),
    .uart_addr  (uart_addr),
    .uart_wdata (uart_wdata),
    .uart_rdata (uart_rdata),
    .txd        (txd),
    .tx_irq     (tx_irq)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Expected frame: bit segments 0..9 (start, d0..d7, stop); segments below
  // sw last len_a cycles, the rest len_b cycles.
  typedef struct {
    logic [7:0]  data;
    int unsigned len_a;
    int unsigned len_b;
    int unsigned sw;
    bit          b2b;
    bit          abort;
  } frame_t;

  frame_t      frame_q[$];
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];

  // Read monitor: data is due one cycle after the read strobe
  initial begin : rd_monitor
    bit          was_rd;
    logic [31:0] exp;
    string       name;
    forever begin
      @(posedge clk);
      was_rd = reset && uart_en && (uart_wen == 4'b0000);
      #1;
      if (was_rd) begin
        if (rd_exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rd_unexpected: read data 0x%0h with nothing queued", uart_rdata);
        end else begin
          exp  = rd_exp_q.pop_front();
          name = rd_name_q.pop_front();
          check(name, uart_rdata, exp);
        end
      end
    end
  end

  // Serial monitor: checks every cycle of each frame against the expected level
  initial begin : tx_monitor
    int unsigned idle_cnt;
    int unsigned bad;
    int unsigned len;
    bit          aborted;
    logic        lvl;
    logic [7:0]  got;
    frame_t      f;
    idle_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) idle_cnt = 0;
      else if (txd === 1'b1) idle_cnt++;
      else if (frame_q.size() == 0) begin
        n_checks++;
        $display("FAIL frame_unexpected: txd low with no frame queued");
      end else begin
        f = frame_q.pop_front();
        if (f.b2b) check("frame_gap", idle_cnt, 0);
        bad = 0; aborted = 1'b0; got = 8'h00;
        for (int seg = 0; seg < 10; seg++) begin
          len = (seg < int'(f.sw)) ? f.len_a : f.len_b;
          lvl = (seg == 0) ? 1'b0 : (seg == 9) ? 1'b1 : f.data[seg-1];
          for (int c = 0; c < int'(len); c++) begin
            if (!aborted) begin
              if (seg != 0 || c != 0) begin
                @(posedge clk);
                #1;
              end
              if (!reset) aborted = 1'b1;
              else begin
                if (txd !== lvl) bad++;
                if (c == 0 && seg >= 1 && seg <= 8) got[seg-1] = txd;
              end
            end
          end
        end
        check("frame_abort", 32'(aborted), 32'(f.abort));
        if (!aborted) begin
          check("frame_data", got, f.data);
          check("frame_timing", bad, 0);
        end
        idle_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data);
    uart_en = 1'b1; uart_wen = wen; uart_addr = addr; uart_wdata = data;
    @(negedge clk);
    uart_en = 1'b0; uart_wen = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    uart_en = 1'b1; uart_wen = 4'b0000; uart_addr = addr;
    @(negedge clk);
    uart_en = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] data, input int unsigned la, input int unsigned lb,
                           input int unsigned sw, input bit b2b, input bit abort);
    frame_t f;
    f.data = data; f.len_a = la; f.len_b = lb; f.sw = sw; f.b2b = b2b; f.abort = abort;
    frame_q.push_back(f);
    bus_write(32'h0, 4'b0001, {24'h0, data});
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while (tx_irq !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", tx_irq, 1);
  endtask

  initial begin : driver
    reset = 1'b0; uart_en = 1'b0; uart_wen = 4'b0000; uart_addr = '0; uart_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_irq", tx_irq, 1);
    check("rst_rdata", uart_rdata, 0);
    reset = 1'b1;
    @(negedge clk);
    bus_read(32'h4, 32'h02, "rst_status");
    bus_read(32'h8, 32'd868, "rst_baud");

    // Single 0xA5 frame at 4 cycles/bit, latency and irq edges
    bus_write(32'h8, 4'b0011, 32'd4);
    bus_read(32'h8, 32'd4, "t1_baud");
    push_byte(8'hA5, 4, 4, 10, 1'b0, 1'b0);
    check("t1_txd_hold", txd, 1);
    check("t1_irq_busy", tx_irq, 0);
    @(negedge clk);
    check("t1_txd_start", txd, 0);
    repeat (39) @(negedge clk);
    check("t1_irq_in_stop", tx_irq, 0);
    @(negedge clk);
    check("t1_irq_done", tx_irq, 1);
    bus_read(32'h4, 32'h02, "t1_status");

    // Three-byte burst at 2 cycles/bit; first byte is popped one cycle after it lands
    bus_write(32'h8, 4'b0011, 32'd2);
    push_byte(8'h00, 2, 2, 10, 1'b0, 1'b0);
    push_byte(8'hFF, 2, 2, 10, 1'b1, 1'b0);
    push_byte(8'h55, 2, 2, 10, 1'b1, 1'b0);
    bus_read(32'h4, 32'h24, "t2_count2");
    repeat (18) @(negedge clk);
    bus_read(32'h4, 32'h14, "t2_count1");
    repeat (19) @(negedge clk);
    bus_read(32'h4, 32'h06, "t2_count0");
    repeat (19) @(negedge clk);
    bus_read(32'h4, 32'h02, "t2_idle");
    check("t2_irq", tx_irq, 1);

    // Overflow: one byte in the shifter, four queued, sixth dropped
    bus_write(32'h8, 4'b0011, 32'd20);
    push_byte(8'h11, 20, 20, 10, 1'b0, 1'b0);
    push_byte(8'h22, 20, 20, 10, 1'b1, 1'b0);
    push_byte(8'h33, 20, 20, 10, 1'b1, 1'b0);
    push_byte(8'h44, 20, 20, 10, 1'b1, 1'b0);
    push_byte(8'h55, 20, 20, 10, 1'b1, 1'b0);
    bus_write(32'h0, 4'b0001, 32'h66);
    bus_read(32'h4, 32'h4D, "t3_full_ovf");
    bus_write(32'h4, 4'b0001, 32'h8);
    bus_read(32'h4, 32'h45, "t3_ovf_clear");
    wait_idle(1200);

    // Push into a full FIFO on the cycle the FSM pops
    bus_write(32'h8, 4'b0011, 32'd2);
    push_byte(8'h3C, 2, 2, 10, 1'b0, 1'b0);
    push_byte(8'hC3, 2, 2, 10, 1'b1, 1'b0);
    push_byte(8'h81, 2, 2, 10, 1'b1, 1'b0);
    push_byte(8'h7E, 2, 2, 10, 1'b1, 1'b0);
    push_byte(8'h96, 2, 2, 10, 1'b1, 1'b0);
    bus_read(32'h4, 32'h45, "t4_full");
    repeat (15) @(negedge clk);
    push_byte(8'h69, 2, 2, 10, 1'b1, 1'b0);
    bus_read(32'h4, 32'h45, "t4_push_pop");
    wait_idle(300);

    // Divisor 0 acts as 1
    bus_write(32'h8, 4'b0011, 32'd0);
    bus_read(32'h8, 32'd0, "t5_baud0");
    push_byte(8'hC3, 1, 1, 10, 1'b0, 1'b0);
    wait_idle(100);

    // Divisor 3 -> 5 during bit 2: new length from bit 3 (segment 4) on
    bus_write(32'h8, 4'b0011, 32'd3);
    push_byte(8'h5A, 3, 5, 4, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    bus_write(32'h8, 4'b0011, 32'd5);
    wait_idle(200);

    // Reset during the data bits abandons the frame
    bus_write(32'h8, 4'b0011, 32'd4);
    bus_read(32'h8, 32'd4, "t6_baud");
    push_byte(8'h00, 4, 4, 10, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check("t6_txd_data", txd, 0);
    reset = 1'b0;
    #1;
    check("t6_rst_txd", txd, 1);
    check("t6_rst_irq", tx_irq, 1);
    check("t6_rst_rdata", uart_rdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_read(32'h4, 32'h02, "t6_status");
    bus_read(32'h8, 32'd868, "t6_baud_rst");
    bus_write(32'hC, 4'b1111, 32'hFFFF_FFFF);
    check("rdata_hold", uart_rdata, 868);
    bus_read(32'hC, 32'h0, "rsvd_read");
    bus_read(32'h0, 32'h0, "txdata_read");
    bus_read(32'h4, 32'h02, "t6_status_after_rsvd");
    bus_read(32'h8, 32'd868, "t6_baud_after_rsvd");

    repeat (5) @(negedge clk);
    check("rd_queue_drained", rd_exp_q.size(), 0);
    check("frame_queue_drained", frame_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
